// File: rtl/req_decoder_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2x4 decoder select path.
// It drives a registered owner index, the decoder enable and a one-hot grant, and it force-releases the owner after MAX_HOLD cycles.
module req_decoder_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       gnt_en,
  output logic [1:0] gnt_id,
  output logic [3:0] grant,
  output logic       timeout
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t        r_state, w_nxt_state;
  logic          r_gnt_en, w_nxt_en;
  logic [1:0]    r_gnt_id, w_nxt_id;
  logic [3:0]    r_grant, w_nxt_grant;
  logic          r_timeout, w_nxt_timeout;
  logic [1:0]    r_ptr, w_nxt_ptr;
  logic [CW-1:0] r_hold_cnt, w_nxt_hold;

  logic          w_found;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;
  logic          w_release;

  // Search starts at ptr and wraps through the 2-bit index.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_release = done[r_gnt_id] | ~req[r_gnt_id];

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_en      = r_gnt_en;
    w_nxt_id      = r_gnt_id;
    w_nxt_ptr     = r_ptr;
    w_nxt_hold    = r_hold_cnt;
    w_nxt_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_nxt_en = 1'b0;
        if (w_found) begin
          w_nxt_state = ST_GRANT;
          w_nxt_en    = 1'b1;
          w_nxt_id    = w_win;
          w_nxt_ptr   = w_win + 2'd1;
          w_nxt_hold  = '0;
        end
      end
      ST_GRANT: begin
        // A normal release takes precedence over the hold limit, so timeout stays low.
        if (w_release) begin
          w_nxt_state = ST_IDLE;
          w_nxt_en    = 1'b0;
        end else if (r_hold_cnt == LIMIT) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_en      = 1'b0;
          w_nxt_timeout = 1'b1;
        end else begin
          w_nxt_hold = r_hold_cnt + CW'(1);
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_en    = 1'b0;
      end
    endcase
    w_nxt_grant = w_nxt_en ? (4'b0001 << w_nxt_id) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_en   <= 1'b0;
      r_gnt_id   <= '0;
      r_grant    <= '0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_gnt_en   <= w_nxt_en;
      r_gnt_id   <= w_nxt_id;
      r_grant    <= w_nxt_grant;
      r_timeout  <= w_nxt_timeout;
      r_ptr      <= w_nxt_ptr;
      r_hold_cnt <= w_nxt_hold;
    end
  end

  assign gnt_en  = r_gnt_en;
  assign gnt_id  = r_gnt_id;
  assign grant   = r_grant;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_req_decoder_arbiter.sv
// Directed-vector bench for req_decoder_arbiter with MAX_HOLD=8.
// Each check packs the observed outputs as {gnt_en, gnt_id, grant, timeout}.
module tb_req_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic       gnt_en;
  logic [1:0] gnt_id;
  logic [3:0] grant;
  logic       timeout;
  logic [7:0] obs;

  int checks   = 0;
  int failures = 0;

  req_decoder_arbiter #(.MAX_HOLD(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .gnt_en (gnt_en),
    .gnt_id (gnt_id),
    .grant  (grant),
    .timeout(timeout)
  );

  assign obs = {gnt_en, gnt_id, grant, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    #12;
    checks++;
    if (obs !== 8'b0_00_0000_0) begin
      $display("FAIL reset_state got=%b exp=%b", obs, 8'b0_00_0000_0);
      failures++;
    end
    rst_n = 1'b1;
    tick();
    req = 4'b0100;
    tick();
    checks++;
    if (obs !== 8'b1_10_0100_0) begin
      $display("FAIL rst_pre_grant got=%b exp=%b", obs, 8'b1_10_0100_0);
      failures++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'b0_00_0000_0) begin
      $display("FAIL rst_async got=%b exp=%b", obs, 8'b0_00_0000_0);
      failures++;
    end
    req   = 4'b0001;
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 8'b1_00_0001_0) begin
      $display("FAIL rst_regrant got=%b exp=%b", obs, 8'b1_00_0001_0);
      failures++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    tick();
    checks++;
    if (obs !== 8'b1_01_0010_0) begin
      $display("FAIL single_grant got=%b exp=%b", obs, 8'b1_01_0010_0);
      failures++;
    end
    tick();
    checks++;
    if (obs !== 8'b1_01_0010_0) begin
      $display("FAIL single_hold got=%b exp=%b", obs, 8'b1_01_0010_0);
      failures++;
    end
    tick();
    done = 4'b0010;
    tick();
    checks++;
    if (obs !== 8'b0_01_0000_0) begin
      $display("FAIL single_release got=%b exp=%b", obs, 8'b0_01_0000_0);
      failures++;
    end
    // The pointer now sits at 2, so 2 wins over 0.
    done = '0;
    req  = 4'b0101;
    tick();
    checks++;
    if (obs !== 8'b1_10_0100_0) begin
      $display("FAIL single_ptr got=%b exp=%b", obs, 8'b1_10_0100_0);
      failures++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] oh;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      oh = 4'b0001 << exp_id[k];
      checks++;
      if (obs !== {1'b1, exp_id[k], oh, 1'b0}) begin
        $display("FAIL rr_grant%0d got=%b exp=%b", k, obs, {1'b1, exp_id[k], oh, 1'b0});
        failures++;
      end
      done = oh;
      tick();
      done = '0;
      checks++;
      if ({gnt_en, grant, timeout} !== 6'b0_0000_0) begin
        $display("FAIL rr_idle%0d got=%b exp=%b", k, {gnt_en, grant, timeout}, 6'b0_0000_0);
        failures++;
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs !== 8'b1_11_1000_0) begin
        $display("FAIL to_hold%0d got=%b exp=%b", k, obs, 8'b1_11_1000_0);
        failures++;
      end
    end
    tick();
    checks++;
    if (obs !== 8'b0_11_0000_1) begin
      $display("FAIL to_pulse got=%b exp=%b", obs, 8'b0_11_0000_1);
      failures++;
    end
    tick();
    checks++;
    if (obs !== 8'b1_11_1000_0) begin
      $display("FAIL to_regrant got=%b exp=%b", obs, 8'b1_11_1000_0);
      failures++;
    end
    done = 4'b1000;
    tick();
    done = '0;
    req  = '0;
    checks++;
    if (obs !== 8'b0_11_0000_0) begin
      $display("FAIL to_release got=%b exp=%b", obs, 8'b0_11_0000_0);
      failures++;
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (obs !== 8'b1_00_0001_0) begin
      $display("FAIL sim_at_limit got=%b exp=%b", obs, 8'b1_00_0001_0);
      failures++;
    end
    done = 4'b0001;
    tick();
    done = '0;
    req  = '0;
    checks++;
    if (obs !== 8'b0_00_0000_0) begin
      $display("FAIL sim_release got=%b exp=%b", obs, 8'b0_00_0000_0);
      failures++;
    end
    tick();
    checks++;
    if (obs !== 8'b0_00_0000_0) begin
      $display("FAIL sim_no_pulse got=%b exp=%b", obs, 8'b0_00_0000_0);
      failures++;
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0100;
    tick();
    done = 4'b0001;
    tick();
    checks++;
    if (obs !== 8'b1_10_0100_0) begin
      $display("FAIL wd_ignored_done got=%b exp=%b", obs, 8'b1_10_0100_0);
      failures++;
    end
    req = 4'b0000;
    tick();
    done = '0;
    checks++;
    if (obs !== 8'b0_10_0000_0) begin
      $display("FAIL wd_release got=%b exp=%b", obs, 8'b0_10_0000_0);
      failures++;
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
